// File: rtl/waveform_to_pipe.sv
// waveform_to_pipe: capture-and-drain sample buffer, ti_clk domain only.
// One 32-bit sample is recorded per sample_tick into on-chip RAM, and the
// host then drains the buffer through an okBTPipeOut endpoint as 16-bit
// words, low half first.
//
// Pipe handshake: pipe_ready is high exactly while the FSM is in DRAIN.
// A pipe_read seen high at a rising edge while pipe_ready is high consumes
// one word; that word appears on pipe_dout one cycle later and holds until
// the next accepted read. pipe_read while pipe_ready is low is ignored.
//
// Optional build macro: WAVEFORM_TO_PIPE_OVERRUN_EN adds overrun_cnt, which
// counts sample_ticks dropped during DRAIN and is sent as one extra word at
// the end of the drain.
//
// DW must be 32: each sample maps onto exactly two pipe words.
module waveform_to_pipe #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DW         = 32
) (
    input  logic          ti_clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          sample_tick,
    input  logic [DW-1:0] sample_in,
    input  logic          pipe_read,
    output logic [15:0]   pipe_dout,
    output logic          pipe_ready,
    output logic          capturing,
    output logic          done,
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
    output logic [15:0]   overrun_cnt,
`endif
    output logic [1:0]    state_dbg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] WR_LAST = '1;
    localparam logic [DEPTH_LOG2:0]   RD_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DW-1:0]         ram [DEPTH];
    logic                  ram_we;
    logic [DW-1:0]         rd_word;
    logic [15:0]           rd_half;

`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
    // Set once every sample word has been sent; the next read returns the tail word.
    logic                  tail_pending;
`endif

    assign state_dbg = state;

    // arm always wins over a coincident tick, so the write is gated by it.
    assign ram_we = (state == ST_CAPTURE) && sample_tick && !arm && !reset;

    // rd_ptr is a word index: upper bits pick the sample, bit 0 picks the half.
    assign rd_word = ram[rd_ptr[DEPTH_LOG2:1]];
    assign rd_half = rd_ptr[0] ? rd_word[31:16] : rd_word[15:0];

    // Sample RAM write port; contents are never read before being rewritten.
    always_ff @(posedge ti_clk) begin
        if (ram_we) begin
            ram[wr_ptr] <= sample_in;
        end
    end

    // Control FSM with registered status outputs and the registered read port.
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pipe_dout    <= '0;
            pipe_ready   <= 1'b0;
            capturing    <= 1'b0;
            done         <= 1'b0;
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
            overrun_cnt  <= '0;
            tail_pending <= 1'b0;
`endif
        end else if (arm) begin
            // Restart from any state; whatever was buffered is abandoned.
            state        <= ST_CAPTURE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pipe_ready   <= 1'b0;
            capturing    <= 1'b1;
            done         <= 1'b0;
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
            overrun_cnt  <= '0;
            tail_pending <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // Waiting for arm; ticks and reads are ignored here.
                end
                ST_CAPTURE: begin
                    if (sample_tick) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == WR_LAST) begin
                            state      <= ST_DRAIN;
                            capturing  <= 1'b0;
                            pipe_ready <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
                    if (sample_tick && (overrun_cnt != 16'hFFFF)) begin
                        overrun_cnt <= overrun_cnt + 16'd1;
                    end
                    if (pipe_read) begin
                        if (tail_pending) begin
                            pipe_dout    <= overrun_cnt;
                            tail_pending <= 1'b0;
                            state        <= ST_IDLE;
                            pipe_ready   <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            pipe_dout <= rd_half;
                            rd_ptr    <= rd_ptr + 1'b1;
                            if (rd_ptr == RD_LAST) begin
                                tail_pending <= 1'b1;
                            end
                        end
                    end
`else
                    if (pipe_read) begin
                        pipe_dout <= rd_half;
                        rd_ptr    <= rd_ptr + 1'b1;
                        if (rd_ptr == RD_LAST) begin
                            state      <= ST_IDLE;
                            pipe_ready <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state      <= ST_IDLE;
                    pipe_ready <= 1'b0;
                    capturing  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_waveform_to_pipe.sv
// Testbench for waveform_to_pipe with a small buffer (DEPTH_LOG2 = 2).
// Reference model keeps the captured samples in a queue and, once the buffer
// is full, expands them into the expected list of pipe words.
module tb_waveform_to_pipe;

    localparam int DL    = 2;
    localparam int DEPTH = 1 << DL;
    localparam int M_IDLE  = 0;
    localparam int M_CAP   = 1;
    localparam int M_DRAIN = 2;

    logic        ti_clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] sample_in = '0;
    logic        pipe_read = 1'b0;
    logic [15:0] pipe_dout;
    logic        pipe_ready;
    logic        capturing;
    logic        done;
    logic [1:0]  state_dbg;
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
    logic [15:0] overrun_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int          m_mode;
    logic [31:0] m_samples[$];
    logic [15:0] exp_q[$];
    logic [15:0] m_dout;
    logic        m_done;
    logic [15:0] m_ovr;
    bit          m_tail;

    waveform_to_pipe #(.DEPTH_LOG2(DL), .DW(32)) dut (
        .ti_clk      (ti_clk),
        .reset       (reset),
        .arm         (arm),
        .sample_tick (sample_tick),
        .sample_in   (sample_in),
        .pipe_read   (pipe_read),
        .pipe_dout   (pipe_dout),
        .pipe_ready  (pipe_ready),
        .capturing   (capturing),
        .done        (done),
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
        .overrun_cnt (overrun_cnt),
`endif
        .state_dbg   (state_dbg)
    );

    // clock / reset
    always #5 ti_clk = ~ti_clk;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_samples.delete();
        exp_q.delete();
        m_dout = '0;
        m_done = 1'b0;
        m_ovr  = '0;
        m_tail = 1'b0;
    endtask

    // One clock of behaviour, from the buffer's externally visible rules.
    task automatic model_apply(input bit a, input bit t, input logic [31:0] s, input bit r);
        if (a) begin
            m_mode = M_CAP;
            m_samples.delete();
            exp_q.delete();
            m_done = 1'b0;
            m_ovr  = '0;
            m_tail = 1'b0;
        end else if (m_mode == M_CAP) begin
            if (t) begin
                m_samples.push_back(s);
                if (m_samples.size() == DEPTH) begin
                    foreach (m_samples[i]) begin
                        exp_q.push_back(m_samples[i][15:0]);
                        exp_q.push_back(m_samples[i][31:16]);
                    end
                    m_mode = M_DRAIN;
                end
            end
        end else if (m_mode == M_DRAIN) begin
            if (r) begin
                if (m_tail) begin
                    m_dout = m_ovr;
                    m_tail = 1'b0;
                    m_mode = M_IDLE;
                    m_done = 1'b1;
                end else begin
                    m_dout = exp_q.pop_front();
                    if (exp_q.size() == 0) begin
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
                        m_tail = 1'b1;
`else
                        m_mode = M_IDLE;
                        m_done = 1'b1;
`endif
                    end
                end
            end
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
            if (t && m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
`endif
        end
    endtask

    // driver: one cycle of inputs, model advanced after the edge
    task automatic step(input bit a, input bit t, input logic [31:0] s, input bit r);
        @(negedge ti_clk);
        arm = a;
        sample_tick = t;
        sample_in = s;
        pipe_read = r;
        @(posedge ti_clk);
        #1;
        model_apply(a, t, s, r);
    endtask

    task automatic apply_reset();
        @(negedge ti_clk);
        reset = 1'b1;
        arm = 1'b0;
        sample_tick = 1'b0;
        pipe_read = 1'b0;
        @(posedge ti_clk);
        @(posedge ti_clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, $urandom, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b0);
        vectors++; if (pipe_dout !== 16'h0000) begin miscompares++; $display("FAIL reset_dout: got %h expected 0000", pipe_dout); end
        vectors++; if (pipe_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", pipe_ready); end
        vectors++; if (capturing !== 1'b0) begin miscompares++; $display("FAIL reset_capturing: got %b expected 0", capturing); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_basic();
        logic [31:0] samp [4];
        logic [15:0] words [8];
        samp  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        words = '{16'h0000, 16'h3F80, 16'h0000, 16'h4000, 16'h0000, 16'h4040, 16'h0000, 16'h4080};
        step(1'b1, 1'b0, '0, 1'b0);
        vectors++; if (capturing !== 1'b1) begin miscompares++; $display("FAIL basic_capturing: got %b expected 1", capturing); end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, samp[i], 1'b0);
        vectors++; if (pipe_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready: got %b expected 1", pipe_ready); end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            vectors++; if (pipe_dout !== words[k]) begin miscompares++; $display("FAIL basic_word%0d: got %h expected %h", k, pipe_dout, words[k]); end
            if (k == 6) begin
                vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_early: got %b expected 0", done); end
            end
        end
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
        step(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (pipe_dout !== 16'h0000) begin miscompares++; $display("FAIL basic_tail: got %h expected 0000", pipe_dout); end
`endif
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done: got %b expected 1", done); end
        vectors++; if (pipe_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_off: got %b expected 0", pipe_ready); end
    endtask

    task automatic test_arm_tick_same();
        logic [31:0] s [4];
        step(1'b1, 1'b1, 32'h3F800000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            s[i] = $urandom;
            step(1'b0, 1'b1, s[i], 1'b0);
        end
        for (int k = 0; k < 2 * DEPTH; k++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            vectors++; if (pipe_dout !== m_dout) begin miscompares++; $display("FAIL armtick_word%0d: got %h expected %h", k, pipe_dout, m_dout); end
        end
        vectors++; if ({s[3][31:16]} !== pipe_dout) begin miscompares++; $display("FAIL armtick_lastword: got %h expected %h", pipe_dout, s[3][31:16]); end
    endtask

    task automatic test_arm_mid_drain();
        logic [31:0] first;
        step(1'b1, 1'b0, '0, 1'b0);
        fill_random();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        vectors++; if (pipe_ready !== 1'b0 || capturing !== 1'b1) begin miscompares++; $display("FAIL middrain_rearm: got ready=%b cap=%b expected ready=0 cap=1", pipe_ready, capturing); end
        first = $urandom;
        step(1'b0, 1'b1, first, 1'b0);
        for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (pipe_dout !== first[15:0]) begin miscompares++; $display("FAIL middrain_word0: got %h expected %h", pipe_dout, first[15:0]); end
        for (int k = 1; k < 2 * DEPTH; k++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            vectors++; if (pipe_dout !== m_dout) begin miscompares++; $display("FAIL middrain_word%0d: got %h expected %h", k, pipe_dout, m_dout); end
        end
    endtask

    task automatic test_read_ignored();
        logic [15:0] held;
        logic [31:0] first;
        // finish any drain left over so the buffer is IDLE
        while (m_mode == M_DRAIN) step(1'b0, 1'b0, '0, 1'b1);
        held = pipe_dout;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (pipe_dout !== held) begin miscompares++; $display("FAIL idle_read_dout: got %h expected %h", pipe_dout, held); end
        vectors++; if (pipe_ready !== 1'b0) begin miscompares++; $display("FAIL idle_read_ready: got %b expected 0", pipe_ready); end
        step(1'b1, 1'b0, '0, 1'b0);
        first = $urandom;
        step(1'b0, 1'b1, first, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (pipe_dout !== held) begin miscompares++; $display("FAIL cap_read_dout: got %h expected %h", pipe_dout, held); end
        for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, $urandom, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (pipe_dout !== first[15:0]) begin miscompares++; $display("FAIL cap_read_word0: got %h expected %h", pipe_dout, first[15:0]); end
    endtask

    task automatic test_reset_mid_drain();
        step(1'b1, 1'b0, '0, 1'b0);
        fill_random();
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        apply_reset();
        vectors++; if ({pipe_dout, pipe_ready, capturing, done} !== 19'd0) begin miscompares++; $display("FAIL midreset: got dout=%h ready=%b cap=%b done=%b expected all 0", pipe_dout, pipe_ready, capturing, done); end
        step(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (pipe_dout !== 16'h0000) begin miscompares++; $display("FAIL midreset_read: got %h expected 0000", pipe_dout); end
    endtask

    task automatic test_random();
        bit a, t, r;
        for (int c = 0; c < 600; c++) begin
            a = ($urandom_range(0, 99) < 2);
            t = ($urandom_range(0, 99) < 45);
            r = ($urandom_range(0, 99) < 55);
            step(a, t, $urandom, r);
            vectors++;
            if (pipe_dout !== m_dout || pipe_ready !== (m_mode == M_DRAIN) ||
                capturing !== (m_mode == M_CAP) || done !== m_done) begin
                miscompares++;
                $display("FAIL random_c%0d: got dout=%h ready=%b cap=%b done=%b expected dout=%h ready=%b cap=%b done=%b",
                         c, pipe_dout, pipe_ready, capturing, done, m_dout, (m_mode == M_DRAIN), (m_mode == M_CAP), m_done);
            end
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
            vectors++; if (overrun_cnt !== m_ovr) begin miscompares++; $display("FAIL random_ovr_c%0d: got %h expected %h", c, overrun_cnt, m_ovr); end
`endif
        end
    endtask

`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
    task automatic test_overrun();
        step(1'b1, 1'b0, '0, 1'b0);
        fill_random();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, $urandom, 1'b0);
        vectors++; if (overrun_cnt !== 16'd5) begin miscompares++; $display("FAIL ovr_count: got %h expected 0005", overrun_cnt); end
        for (int k = 0; k < 2 * DEPTH; k++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            vectors++; if (pipe_dout !== m_dout) begin miscompares++; $display("FAIL ovr_word%0d: got %h expected %h", k, pipe_dout, m_dout); end
        end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL ovr_done_early: got %b expected 0", done); end
        step(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (pipe_dout !== 16'h0005) begin miscompares++; $display("FAIL ovr_tail: got %h expected 0005", pipe_dout); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ovr_done: got %b expected 1", done); end
        step(1'b1, 1'b0, '0, 1'b0);
        vectors++; if (overrun_cnt !== 16'd0) begin miscompares++; $display("FAIL ovr_arm_clear: got %h expected 0000", overrun_cnt); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_arm_tick_same();
        test_arm_mid_drain();
        test_read_ignored();
        test_reset_mid_drain();
`ifdef WAVEFORM_TO_PIPE_OVERRUN_EN
        test_overrun();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
